sobel_window_buffer: RTL and testbench
======================================

Name: sobel_window_buffer

Overview:
- Custom-instruction block sitting directly upstream of the Sobel edge-detection instruction.
- Software streams a grayscale frame into it, 4 pixels per instruction, and it stores the pixels in three rotating line buffers.
- On request it fetches the 3x3 neighbourhood around a column and returns it packed exactly as the edge-detection instruction consumes it: word0 = pixels 0-3, word1 = pixels 4-7, pixel8 = a separate byte. Pixels are row-major and top-left first.

Parameters:
- customInstructionId, 8'd0, ciN value this block answers to.
- MAX_WIDTH, 640, maximum line width in pixels; a multiple of 4; sets each line-buffer depth to MAX_WIDTH/4 words of 32 bits.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising clock edge resets the block).
- start  input  1  CPU custom-instruction strobe.
- valueA  input  32  operand A (pixel data, width, or column x).
- valueB  input  32  operand B; valueB[7:0] = opcode.
- ciN  input  8  custom-instruction number.
- done  output  1  instruction complete.
- result  output  32  instruction result; 0 whenever done==0.

Behaviour:
- Selection: sel = start && (ciN==customInstructionId). No response if ciN mismatches.
- Reset:
  - done=0, result=0.
  - width=MAX_WIDTH, col_word=0, wr_row=0, rows_done=0.
  - Window registers = 0; FSM = IDLE.
  - Line-buffer contents are not cleared.
- Opcode 0x00 CONFIG:
  - width = valueA[15:0], clears col_word, wr_row and rows_done.
  - done is combinational in the same cycle; result = 0.
  - An illegal width (0, not a multiple of 4, or > MAX_WIDTH) is replaced by MAX_WIDTH and result = 1.
- Opcode 0x01 PUSH:
  - Writes valueA into row buffer wr_row at address col_word; byte0 is the leftmost pixel.
  - done is combinational in the same cycle; result = 0.
  - col_word increments. When col_word == width/4-1 it wraps to 0, wr_row advances 0->1->2->0, and rows_done increments, saturating at 16'hFFFF.
- Opcode 0x02 FETCH (multi-cycle), valueA[15:0] = center column x:
  - Error case, when any of: rows_done<3, col_word!=0, x==0, x>=width-1.
    - done at T+1 with result 32'hFFFFFFFF.
    - Window registers unchanged; FSM stays IDLE.
  - Otherwise the FSM runs IDLE -> RD_LO -> RD_HI -> ASSEMBLE -> DONE:
    - RD_LO addresses word (x-1)>>2 in all three buffers.
    - RD_HI addresses word (x+1)>>2; RAM read latency is 1 cycle.
    - ASSEMBLE extracts bytes x-1, x and x+1 of each row; the 2 words are always read, even when identical.
    - DONE pulses done for 1 cycle at T+4 with result = {p3,p2,p1,p0}, then returns to IDLE.
  - Row mapping:
    - top = buffer wr_row (oldest).
    - middle = (wr_row+1)%3.
    - bottom = (wr_row+2)%3 (newest).
  - Window registers p0..p8 update in ASSEMBLE.
- Opcode 0x03 WIN_HI: combinational done; result = {p7,p6,p5,p4}.
- Opcode 0x04 WIN_P8: combinational done; result = {24'd0,p8}.
- Opcode 0x05 STATUS: combinational done; result = {rows_done[15:0], 6'd0, col_word[9:0]}.
- Other opcodes: combinational done; result = 0; no state change.
- Boundaries:
  - A start of any opcode while the FSM is not IDLE is ignored: no done, no state change.
  - A reset asserted mid-FETCH aborts it: done stays 0 and the FSM returns to IDLE.
  - CONFIG mid-row discards the partial row.
  - rows_done saturation does not stop the buffer rotation.

Test Plan:
- Reset, then STATUS -> result 0. CONFIG with valueA=8 -> result 0. STATUS -> result 0.
- CONFIG width=8; push 3 rows where row r, pixel i = 16*r+i (words such as 0x03020100, 0x07060504). FETCH x=4 -> done exactly 4 cycles after start, result 0x05040303? Packed as {p3,p2,p1,p0} = {0x13,0x05,0x04,0x03} = 0x13050403. Then WIN_HI -> 0x24231514 and WIN_P8 -> 0x00000025.
- FETCH x=0, FETCH x=7, and FETCH after only 2 rows -> each gives done at T+1 and result 0xFFFFFFFF; a following WIN_HI returns the previous window unchanged.
- Push a 4th row of value 0x3X, then FETCH x=1 -> rows 1, 2 and 3 are used: p0=0x10, p4=0x21, p8=0x32. Push one word, then FETCH -> error, because col_word != 0.
- CONFIG width=6 -> result 1 and width = MAX_WIDTH. Wrong ciN with start -> done 0 and result 0.
- Start a FETCH, drive reset=0 at T+2 -> no done pulse; after release, STATUS -> 0 and a PUSH completes in the same cycle.

Source files
------------

// File: rtl/sobel_window_buffer.sv
// Sobel window buffer: streams pixels into three rotating line buffers and returns the
// 3x3 neighbourhood around a column, packed for the edge-detection instruction.
module sobel_window_buffer #(
  parameter logic [7:0]  customInstructionId = 8'd0,
  parameter int unsigned MAX_WIDTH           = 640
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned Depth = MAX_WIDTH / 4;
  localparam int unsigned Aw    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [15:0] MaxW  = 16'(MAX_WIDTH);

  localparam logic [7:0] OpConfig = 8'h00;
  localparam logic [7:0] OpPush   = 8'h01;
  localparam logic [7:0] OpFetch  = 8'h02;
  localparam logic [7:0] OpWinHi  = 8'h03;
  localparam logic [7:0] OpWinP8  = 8'h04;
  localparam logic [7:0] OpStatus = 8'h05;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRdLo = 3'd1;
  localparam logic [2:0] StRdHi = 3'd2;
  localparam logic [2:0] StAsm  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]  state_q;
  logic [15:0] width_q;
  logic [15:0] col_word_q;
  logic [1:0]  wr_row_q;
  logic [15:0] rows_done_q;
  logic [15:0] x_q;
  logic        err_q;
  logic [7:0]  p_q [9];
  logic [31:0] lo_q [3];
  logic [31:0] rd_q [3];
  logic [31:0] mem [3][Depth];

  logic [7:0]  op;
  logic        accept;
  logic        push_we;
  logic        cfg_bad;
  logic        fetch_bad;
  logic        last_word;
  logic [15:0] cfg_w;
  logic [15:0] fetch_x;
  logic [15:0] x_m1;
  logic [15:0] x_p1;
  logic [15:0] lo_word;
  logic [15:0] hi_word;
  logic [Aw-1:0] rd_addr;
  logic [Aw-1:0] wr_addr;
  logic [7:0]  asm_px [9];
  logic        unused_bits;

  assign op      = valueB[7:0];
  // A pending error response counts as busy so it cannot collide with a new instruction.
  assign accept  = start && (ciN == customInstructionId) && (state_q == StIdle) && !err_q;
  assign push_we = accept && (op == OpPush) && reset;

  assign cfg_w     = valueA[15:0];
  assign cfg_bad   = (cfg_w == 16'd0) || (cfg_w[1:0] != 2'd0) || (cfg_w > MaxW);
  assign fetch_x   = valueA[15:0];
  assign fetch_bad = (rows_done_q < 16'd3) || (col_word_q != 16'd0) || (fetch_x == 16'd0) ||
                     (fetch_x >= width_q - 16'd1);
  assign last_word = (col_word_q == (width_q >> 2) - 16'd1);

  assign x_m1    = x_q - 16'd1;
  assign x_p1    = x_q + 16'd1;
  assign lo_word = {2'b00, x_m1[15:2]};
  assign hi_word = {2'b00, x_p1[15:2]};
  assign rd_addr = (state_q == StRdLo) ? lo_word[Aw-1:0] : hi_word[Aw-1:0];
  assign wr_addr = col_word_q[Aw-1:0];

  assign unused_bits = ^{valueA[31:16], valueB[31:8], lo_word, hi_word, x_p1, col_word_q};

  function automatic logic [1:0] row_buf(input logic [1:0] w, input logic [1:0] r);
    logic [2:0] s;
    s = {1'b0, w} + {1'b0, r};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (push_we && (wr_row_q == 2'(i))) mem[i][wr_addr] <= valueA;
      rd_q[i] <= mem[i][rd_addr];
    end
  end

  // Row r of the window comes from buffer (wr_row + r) % 3; the pixels sit at byte
  // offset (x-1)&3 of the {hi, lo} word pair, which also covers the same-word case.
  always_comb begin
    logic [1:0]  b;
    logic [63:0] sh;
    for (int r = 0; r < 9; r++) asm_px[r] = 8'd0;
    for (int r = 0; r < 3; r++) begin
      b  = row_buf(wr_row_q, 2'(r));
      sh = {rd_q[b], lo_q[b]} >> {x_m1[1:0], 3'b000};
      asm_px[3*r]     = sh[7:0];
      asm_px[3*r + 1] = sh[15:8];
      asm_px[3*r + 2] = sh[23:16];
    end
  end

  always_comb begin
    done   = 1'b0;
    result = 32'd0;
    if (state_q == StDone) begin
      done   = 1'b1;
      result = {p_q[3], p_q[2], p_q[1], p_q[0]};
    end else if (err_q) begin
      done   = 1'b1;
      result = 32'hFFFF_FFFF;
    end else if (accept) begin
      unique case (op)
        OpConfig: begin done = 1'b1; result = {31'd0, cfg_bad}; end
        OpFetch:  done = 1'b0;
        OpWinHi:  begin done = 1'b1; result = {p_q[7], p_q[6], p_q[5], p_q[4]}; end
        OpWinP8:  begin done = 1'b1; result = {24'd0, p_q[8]}; end
        OpStatus: begin done = 1'b1; result = {rows_done_q, 6'd0, col_word_q[9:0]}; end
        default:  done = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      width_q     <= MaxW;
      col_word_q  <= 16'd0;
      wr_row_q    <= 2'd0;
      rows_done_q <= 16'd0;
      x_q         <= 16'd0;
      err_q       <= 1'b0;
      for (int i = 0; i < 9; i++) p_q[i] <= 8'd0;
      for (int i = 0; i < 3; i++) lo_q[i] <= 32'd0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (op == OpConfig) begin
              width_q     <= cfg_bad ? MaxW : cfg_w;
              col_word_q  <= 16'd0;
              wr_row_q    <= 2'd0;
              rows_done_q <= 16'd0;
            end else if (op == OpPush) begin
              if (last_word) begin
                col_word_q <= 16'd0;
                wr_row_q   <= (wr_row_q == 2'd2) ? 2'd0 : wr_row_q + 2'd1;
                if (rows_done_q != 16'hFFFF) rows_done_q <= rows_done_q + 16'd1;
              end else begin
                col_word_q <= col_word_q + 16'd1;
              end
            end else if (op == OpFetch) begin
              if (fetch_bad) begin
                err_q <= 1'b1;
              end else begin
                x_q     <= fetch_x;
                state_q <= StRdLo;
              end
            end
          end
        end
        StRdLo: state_q <= StRdHi;
        StRdHi: begin
          lo_q    <= rd_q;
          state_q <= StAsm;
        end
        StAsm: begin
          p_q     <= asm_px;
          state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer: line streaming, window fetch, error paths, reset abort.
module tb_sobel_window_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] valueA = 32'd0;
  logic [31:0] valueB = 32'd0;
  logic [7:0]  ciN = 8'd0;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int passes = 0;

  sobel_window_buffer #(
    .customInstructionId(8'd0),
    .MAX_WIDTH(640)
  ) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .valueA(valueA),
    .valueB(valueB),
    .ciN   (ciN),
    .done  (done),
    .result(result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Single-cycle instruction: done and result must be valid in the issuing cycle.
  task automatic ci(input logic [7:0] op, input logic [31:0] a, input logic [31:0] exp,
                    input string tag);
    @(negedge clock);
    start = 1'b1; valueA = a; valueB = {24'd0, op}; ciN = 8'd0;
    #1;
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check(tag, result, exp);
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] x, input int exp_lat, input logic [31:0] exp,
                       input string tag);
    int lat;
    logic [31:0] res;
    lat = 0;
    res = 32'd0;
    @(negedge clock);
    start = 1'b1; valueA = {16'd0, x}; valueB = 32'h2; ciN = 8'd0;
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check(tag, res, exp);
    @(negedge clock);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic push_row(input int r, input int words);
    logic [31:0] d;
    for (int w = 0; w < words; w++) begin
      for (int i = 0; i < 4; i++) d[8*i +: 8] = 8'(16 * r + 4 * w + i);
      ci(8'h01, d, 32'd0, "push");
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    ci(8'h05, 32'd0, 32'd0, "status_rst");
    ci(8'h00, 32'd8, 32'd0, "cfg8");
    ci(8'h05, 32'd0, 32'd0, "status_cfg");

    push_row(0, 2);
    push_row(1, 2);
    push_row(2, 2);
    ci(8'h05, 32'd0, 32'h0003_0000, "status_3rows");

    fetch(16'd4, 4, 32'h1305_0403, "fetch_x4");
    ci(8'h03, 32'd0, 32'h2423_1514, "winhi_x4");
    ci(8'h04, 32'd0, 32'h0000_0025, "winp8_x4");

    fetch(16'd0, 1, 32'hFFFF_FFFF, "fetch_x0");
    fetch(16'd7, 1, 32'hFFFF_FFFF, "fetch_x7");
    ci(8'h03, 32'd0, 32'h2423_1514, "winhi_keep");

    push_row(3, 2);
    fetch(16'd1, 4, 32'h2012_1110, "fetch_x1");
    ci(8'h03, 32'd0, 32'h3130_2221, "winhi_x1");
    ci(8'h04, 32'd0, 32'h0000_0032, "winp8_x1");

    ci(8'h01, 32'hAABB_CCDD, 32'd0, "push_partial");
    fetch(16'd4, 1, 32'hFFFF_FFFF, "fetch_colword");
    ci(8'h03, 32'd0, 32'h3130_2221, "winhi_keep2");

    ci(8'h00, 32'd8, 32'd0, "cfg8_again");
    push_row(5, 2);
    push_row(6, 2);
    ci(8'h05, 32'd0, 32'h0002_0000, "status_2rows");
    fetch(16'd4, 1, 32'hFFFF_FFFF, "fetch_2rows");

    ci(8'h00, 32'd6, 32'd1, "cfg6");
    ci(8'h05, 32'd0, 32'd0, "status_cfg6");
    push_row(7, 3);
    ci(8'h05, 32'd0, 32'h0000_0003, "status_w640");
    ci(8'h07, 32'd0, 32'd0, "bad_opcode");

    @(negedge clock);
    start = 1'b1; valueA = 32'd0; valueB = 32'h5; ciN = 8'h05;
    #1;
    check("wrong_cin_done", {31'd0, done}, 32'd0);
    check("wrong_cin_result", result, 32'd0);
    @(posedge clock);
    #1 start = 1'b0; ciN = 8'd0;
    ci(8'h05, 32'd0, 32'h0000_0003, "status_after_cin");

    ci(8'h00, 32'd8, 32'd0, "cfg8_abort");
    push_row(8, 2);
    push_row(9, 2);
    push_row(10, 2);
    @(negedge clock);
    start = 1'b1; valueA = 32'd4; valueB = 32'h2;
    @(posedge clock);
    #1 start = 1'b0;
    @(negedge clock);
    check("abort_t1", {31'd0, done}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("abort_t2", {31'd0, done}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    ci(8'h05, 32'd0, 32'd0, "status_after_abort");
    ci(8'h01, 32'h1234_5678, 32'd0, "push_after_abort");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
